jt12_op_gen: RTL and testbench

- Parametrised, pipelined FM operator for the jt12 family. One operator slot is processed per clk_en.
- Converts phase plus phase-modulation and EG attenuation into a signed sample, using a log-sine/exp pipeline.
- Generalises the fixed 6-voice, 9-bit, sine-only operator:
  - voice count is configurable;
  - output width is configurable;
  - slot-1 self-feedback is kept internally, per voice;
  - optional OPL-style waveform select.
- Sits between the PG/EG stages and the channel accumulator.

---
 rtl/jt12_op_gen.sv | 220 ++++++++++++++++++++++
 tb/tb_jt12_op_gen.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/jt12_op_gen.sv
`default_nettype none
// ============================================================================
// Module  : jt12_op_gen
// Brief   : Pipelined log-sine/exp FM operator with per-voice S1 feedback.
//           Optional OPL waveform select when JT12_OP_WAVE_EN is defined.
// Revision: 1.0
// ============================================================================
module jt12_op_gen #(
  parameter int NUM_VOICES = 6,
  parameter int OUT_W      = 9,
  localparam int VW        = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [VW-1:0]    voice,
  input  logic [1:0]       slot,
  input  logic [9:0]       phase_in,
  input  logic [13:0]      pm_in,
  input  logic [2:0]       fb,
  input  logic [1:0]       wave,
  input  logic [9:0]       atten,
  output logic [OUT_W-1:0] op_out,
  output logic [VW-1:0]    op_voice,
  output logic [1:0]       op_slot
);

  localparam int          NSTORE = 1 << VW;
  localparam logic [VW:0] C_NV   = NUM_VOICES[VW:0];
  localparam longint      C_ONE  = 64'sd1 << 30;
  localparam longint      C_PI   = 64'sd3373259426;
  localparam longint      C_LN2  = 64'sd744261118;

  // ROM contents are fixed at elaboration from the closed forms, Q30 integer maths.
  function automatic logic [11:0] ls_entry(input int i);
    longint t, t2, term, s, m, l;
    int     k;
    t    = (longint'(2 * i + 1) * C_PI) >>> 10;
    t2   = (t * t) >>> 30;
    term = t;
    s    = t;
    for (int n = 1; n <= 12; n++) begin
      term = -((term * t2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    m = s;
    k = 0;
    for (int j = 0; j < 16; j++) begin
      if (m < C_ONE) begin
        m = m <<< 1;
        k = k + 1;
      end
    end
    l = 0;
    for (int b = 0; b < 20; b++) begin
      m = (m * m) >>> 30;
      l = l <<< 1;
      if (m >= 2 * C_ONE) begin
        m = m >>> 1;
        l = l + 1;
      end
    end
    return 12'(((longint'(k) <<< 20) - l + 2048) >>> 12);
  endfunction

  function automatic logic [9:0] ex_entry(input int i);
    longint y, term, s;
    y    = (longint'(i) * C_LN2) >>> 8;
    term = C_ONE;
    s    = C_ONE;
    for (int n = 1; n <= 14; n++) begin
      term = ((term * y) >>> 30) / longint'(n);
      s    = s + term;
    end
    return 10'((((s <<< 10) + (C_ONE >>> 1)) >>> 30) - 1024);
  endfunction

  logic [11:0] w_ls_rom [256];
  logic [9:0]  w_ex_rom [256];

  for (genvar g = 0; g < 256; g++) begin : g_rom
    localparam logic [11:0] C_LS = ls_entry(g);
    localparam logic [9:0]  C_EX = ex_entry(g);
    assign w_ls_rom[g] = C_LS;
    assign w_ex_rom[g] = C_EX;
  end

  logic [13:0]   r_fb1 [NSTORE];
  logic [13:0]   r_fb2 [NSTORE];

  logic [7:0]    r1_idx;
  logic          r1_sign;
  logic [9:0]    r1_atten;
  logic [VW-1:0] r1_voice;
  logic [1:0]    r1_slot;
`ifdef JT12_OP_WAVE_EN
  logic          r1_kill;
`endif
  logic [11:0]   r2_ta;
  logic          r2_sign;
  logic [VW-1:0] r2_voice;
  logic [1:0]    r2_slot;
  logic [12:0]   r3_mag;
  logic          r3_sign;
  logic [VW-1:0] r3_voice;
  logic [1:0]    r3_slot;
  logic [13:0]   r_result;
  logic [VW-1:0] r_op_voice;
  logic [1:0]    r_op_slot;

  logic [14:0]   w_fb_sum;
  logic [14:0]   w_fb_shr;
  logic [9:0]    w_pm;
  logic [9:0]    w_p;
  logic [7:0]    w_idx;
  logic          w_sign;
`ifdef JT12_OP_WAVE_EN
  logic          w_kill;
`endif
  logic [12:0]   w_ta_sum;
  logic [11:0]   w_ta;
  logic [12:0]   w_mag;
  logic [13:0]   w_res;
  logic          w_unused;

  always_comb begin
    w_fb_sum = {r_fb1[voice][13], r_fb1[voice]} + {r_fb2[voice][13], r_fb2[voice]};
    w_fb_shr = $signed(w_fb_sum) >>> (4'd10 - {1'b0, fb});
    if (slot != 2'd0)    w_pm = pm_in[10:1];
    else if (fb == 3'd0) w_pm = 10'd0;
    else                 w_pm = w_fb_shr[9:0];
    w_p    = phase_in + w_pm;
    w_idx  = w_p[8] ? ~w_p[7:0] : w_p[7:0];
    w_sign = w_p[9];
`ifdef JT12_OP_WAVE_EN
    w_kill = 1'b0;
    case (wave)
      2'd1:    begin w_kill = w_p[9]; w_sign = 1'b0; end
      2'd2:    w_sign = 1'b0;
      2'd3:    begin w_kill = w_p[8]; w_sign = 1'b0; end
      default: w_kill = 1'b0;
    endcase
`endif
  end

  always_comb begin
    w_ta_sum = {1'b0, r1_atten, 2'b00} + {1'b0, w_ls_rom[r1_idx]};
    w_ta     = w_ta_sum[12] ? 12'hFFF : w_ta_sum[11:0];
`ifdef JT12_OP_WAVE_EN
    if (r1_kill) w_ta = 12'hFFF;
`endif
    w_mag = {1'b1, w_ex_rom[~r2_ta[7:0]], 2'b00} >> r2_ta[11:8];
    w_res = r3_sign ? (14'd0 - {1'b0, r3_mag}) : {1'b0, r3_mag};
  end

`ifdef JT12_OP_WAVE_EN
  assign w_unused = ^{pm_in[13:11], pm_in[0], w_fb_shr[14:10]};
`else
  assign w_unused = ^{pm_in[13:11], pm_in[0], w_fb_shr[14:10], wave};
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r1_idx     <= '0;
      r1_sign    <= 1'b0;
      r1_atten   <= '0;
      r1_voice   <= '0;
      r1_slot    <= '0;
`ifdef JT12_OP_WAVE_EN
      r1_kill    <= 1'b0;
`endif
      r2_ta      <= '0;
      r2_sign    <= 1'b0;
      r2_voice   <= '0;
      r2_slot    <= '0;
      r3_mag     <= '0;
      r3_sign    <= 1'b0;
      r3_voice   <= '0;
      r3_slot    <= '0;
      r_result   <= '0;
      r_op_voice <= '0;
      r_op_slot  <= '0;
      for (int v = 0; v < NSTORE; v++) begin
        r_fb1[v] <= '0;
        r_fb2[v] <= '0;
      end
    end else if (clk_en) begin
      r1_idx     <= w_idx;
      r1_sign    <= w_sign;
      r1_atten   <= atten;
      r1_voice   <= voice;
      r1_slot    <= slot;
`ifdef JT12_OP_WAVE_EN
      r1_kill    <= w_kill;
`endif
      r2_ta      <= w_ta;
      r2_sign    <= r1_sign;
      r2_voice   <= r1_voice;
      r2_slot    <= r1_slot;
      r3_mag     <= w_mag;
      r3_sign    <= r2_sign;
      r3_voice   <= r2_voice;
      r3_slot    <= r2_slot;
      r_result   <= w_res;
      r_op_voice <= r3_voice;
      r_op_slot  <= r3_slot;
      // Stage-1 reads see the old store contents; out-of-range voices never write.
      if (r3_slot == 2'd0 && ({1'b0, r3_voice} < C_NV)) begin
        r_fb1[r3_voice] <= w_res;
        r_fb2[r3_voice] <= r_fb1[r3_voice];
      end
    end
  end

  assign op_out   = r_result[13 -: OUT_W];
  assign op_voice = r_op_voice;
  assign op_slot  = r_op_slot;

endmodule
`default_nettype wire

// File: tb/tb_jt12_op_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_jt12_op_gen
// Brief   : Directed self-checking bench for jt12_op_gen (default parameters).
// Revision: 1.0
// ============================================================================
module tb_jt12_op_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en;
  logic [2:0] voice;
  logic [1:0] slot;
  logic [9:0] phase_in;
  logic [13:0] pm_in;
  logic [2:0] fb;
  logic [1:0] wave;
  logic [9:0] atten;
  logic [8:0] op_out;
  logic [2:0] op_voice;
  logic [1:0] op_slot;

  int checks = 0;
  int errors = 0;

  jt12_op_gen dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .voice    (voice),
    .slot     (slot),
    .phase_in (phase_in),
    .pm_in    (pm_in),
    .fb       (fb),
    .wave     (wave),
    .atten    (atten),
    .op_out   (op_out),
    .op_voice (op_voice),
    .op_slot  (op_slot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic filler();
    voice = 3'd0; slot = 2'd1; phase_in = 10'd0; pm_in = 14'd0;
    fb = 3'd0; wave = 2'd0; atten = 10'h3FF;
  endtask

  task automatic tick(input logic en);
    clk_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] v, input logic [1:0] s, input logic [9:0] ph,
                       input logic [13:0] pm, input logic [2:0] f, input logic [1:0] w,
                       input logic [9:0] a);
    voice = v; slot = s; phase_in = ph; pm_in = pm; fb = f; wave = w; atten = a;
    tick(1'b1);
    filler();
    tick(1'b1);
    tick(1'b1);
    tick(1'b1);
  endtask

  initial begin
    rst = 1'b0;
    clk_en = 1'b0;
    filler();
    tick(1'b0);
    tick(1'b0);
    check("reset_out",   16'(op_out),   16'h000);
    check("reset_voice", 16'(op_voice), 16'h0);
    check("reset_slot",  16'(op_slot),  16'h0);
    rst = 1'b1;
    tick(1'b1);
    tick(1'b1);

    // Fresh store: S1 with fb=7 sees zero feedback
    issue(3'd2, 2'd0, 10'h0FF, 14'd0, 3'd7, 2'd0, 10'd0);
    check("s1_zero_store", 16'(op_out),   16'h0FF);
    check("s1_voice",      16'(op_voice), 16'h2);
    check("s1_slot",       16'(op_slot),  16'h0);

    issue(3'd3, 2'd1, 10'h0FF, 14'd0, 3'd0, 2'd0, 10'd0);
    check("peak_pos",  16'(op_out),   16'h0FF);
    check("peak_tagv", 16'(op_voice), 16'h3);
    check("peak_tags", 16'(op_slot),  16'h1);
    issue(3'd3, 2'd1, 10'h2FF, 14'd0, 3'd0, 2'd0, 10'd0);
    check("peak_neg", 16'(op_out), 16'h100);

    issue(3'd4, 2'd2, 10'h102, 14'h3FFA, 3'd0, 2'd0, 10'd0);
    check("pm_minus6", 16'(op_out), 16'h0FF);
    issue(3'd5, 2'd3, 10'h0FF, 14'h0400, 3'd0, 2'd0, 10'd0);
    check("pm_1024", 16'(op_out), 16'h100);
    check("pm_tags", 16'(op_slot), 16'h3);

    issue(3'd1, 2'd1, 10'h0FF, 14'd0, 3'd0, 2'd0, 10'h3FF);
    check("atten_max", 16'(op_out), 16'h000);
    issue(3'd1, 2'd1, 10'h0FF, 14'd0, 3'd0, 2'd0, 10'h020);
    check("atten_32", 16'(op_out), 16'h0B4);
    issue(3'd1, 2'd1, 10'h2FF, 14'd0, 3'd0, 2'd0, 10'h100);
    check("atten_256_neg", 16'(op_out), 16'h1F0);

    // Enable gating: result only after the 4th enabled edge
    voice = 3'd1; slot = 2'd1; phase_in = 10'h0FF; pm_in = 14'd0; fb = 3'd0; wave = 2'd0; atten = 10'd0;
    tick(1'b1);
    filler();
    tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    check("gate_early_voice", 16'(op_voice), 16'h0);
    check("gate_early_slot",  16'(op_slot),  16'h1);
    tick(1'b1);
    check("gate_out",   16'(op_out),   16'h0FF);
    check("gate_voice", 16'(op_voice), 16'h1);
    tick(1'b0);
    tick(1'b0);
    check("gate_hold", 16'(op_out), 16'h0FF);

    // Feedback: voice 2 store holds fb1=8168, fb2=0
    issue(3'd2, 2'd0, 10'h201, 14'd0, 3'd0, 2'd0, 10'd0);
    check("fb0_no_pm", 16'(op_out), 16'h1FD);
    issue(3'd1, 2'd0, 10'h0FF, 14'd0, 3'd0, 2'd0, 10'd0);
    check("fb_seed", 16'(op_out), 16'h0FF);
    issue(3'd1, 2'd0, 10'h201, 14'd0, 3'd7, 2'd0, 10'd0);
    check("fb7_pm1021", 16'(op_out), 16'h002);
    issue(3'd2, 2'd0, 10'h20A, 14'd0, 3'd7, 2'd0, 10'd0);
    check("fb7_two_taps", 16'(op_out), 16'h003);

    // Voice outside NUM_VOICES passes through but never stores
    issue(3'd7, 2'd0, 10'h0FF, 14'd0, 3'd0, 2'd0, 10'd0);
    check("oob_out",   16'(op_out),   16'h0FF);
    check("oob_voice", 16'(op_voice), 16'h7);
    issue(3'd7, 2'd0, 10'h201, 14'd0, 3'd7, 2'd0, 10'd0);
    check("oob_no_store", 16'(op_out), 16'h1FD);

    issue(3'd0, 2'd1, 10'h2FF, 14'd0, 3'd0, 2'd1, 10'd0);
`ifdef JT12_OP_WAVE_EN
    check("wave1_half", 16'(op_out), 16'h000);
`else
    check("wave1_ignored", 16'(op_out), 16'h100);
`endif
    issue(3'd0, 2'd1, 10'h2FF, 14'd0, 3'd0, 2'd2, 10'd0);
`ifdef JT12_OP_WAVE_EN
    check("wave2_abs", 16'(op_out), 16'h0FF);
`else
    check("wave2_ignored", 16'(op_out), 16'h100);
`endif
    issue(3'd0, 2'd1, 10'h100, 14'd0, 3'd0, 2'd3, 10'd0);
`ifdef JT12_OP_WAVE_EN
    check("wave3_pulse", 16'(op_out), 16'h000);
`else
    check("wave3_ignored", 16'(op_out), 16'h0FF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
